// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - parallel-to-serial operand feeder for the bit-serial adder
// Loads an operand pair, streams it LSB-first with the adder clear and a final-result done pulse.
module serial_operand_feeder #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     op_a,
    input  logic [N-1:0]     op_b,
    input  logic             abort,
    output logic             a_bit,
    output logic             b_bit,
    output logic             sa_reset,
    output logic [IDX_W-1:0] bit_idx,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t         state;
    logic [N-1:0]   sh_a;
    logic [N-1:0]   sh_b;
    logic [IDX_W-1:0] idx_next;

    assign idx_next = bit_idx + IDX_W'(1);

    // Every output is a flop loaded alongside the state, so the adder never sees
    // a combinational path from in_valid/abort/op_* and nothing glitches mid-cycle.
    // The shift registers hold the bits still to come; bit 0 is already on a_bit/b_bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            bit_idx  <= '0;
            in_ready <= 1'b1;
            sa_reset <= 1'b1;
            a_bit    <= 1'b0;
            b_bit    <= 1'b0;
            last_bit <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort wins over an acceptance presented in the same cycle
                    if (in_valid && in_ready && !abort) begin
                        state    <= SHIFT;
                        sh_a     <= op_a >> 1;
                        sh_b     <= op_b >> 1;
                        a_bit    <= op_a[0];
                        b_bit    <= op_b[0];
                        bit_idx  <= '0;
                        last_bit <= 1'b0;
                        in_ready <= 1'b0;
                        sa_reset <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state    <= IDLE;
                        sh_a     <= '0;
                        sh_b     <= '0;
                        bit_idx  <= '0;
                        in_ready <= 1'b1;
                        sa_reset <= 1'b1;
                        a_bit    <= 1'b0;
                        b_bit    <= 1'b0;
                        last_bit <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else if (bit_idx == LAST_IDX) begin
                        state    <= DONE;
                        bit_idx  <= '0;
                        a_bit    <= 1'b0;
                        b_bit    <= 1'b0;
                        last_bit <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        a_bit    <= sh_a[0];
                        b_bit    <= sh_b[0];
                        sh_a     <= sh_a >> 1;
                        sh_b     <= sh_b >> 1;
                        bit_idx  <= idx_next;
                        last_bit <= (idx_next == LAST_IDX);
                    end
                end

                DONE: begin
                    // the adder keeps its result through this cycle and is cleared from the next
                    state    <= IDLE;
                    sh_a     <= '0;
                    sh_b     <= '0;
                    bit_idx  <= '0;
                    in_ready <= 1'b1;
                    sa_reset <= 1'b1;
                    a_bit    <= 1'b0;
                    b_bit    <= 1'b0;
                    last_bit <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    sh_a     <= '0;
                    sh_b     <= '0;
                    bit_idx  <= '0;
                    in_ready <= 1'b1;
                    sa_reset <= 1'b1;
                    a_bit    <= 1'b0;
                    b_bit    <= 1'b0;
                    last_bit <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - scoreboard bench for serial_operand_feeder
module tb_serial_operand_feeder;

    localparam int N = 4;
    localparam int IDX_W = $clog2(N);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             abort;
    logic             a_bit;
    logic             b_bit;
    logic             sa_reset;
    logic [IDX_W-1:0] bit_idx;
    logic             last_bit;
    logic             busy;
    logic             done;

    serial_operand_feeder #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .abort    (abort),
        .a_bit    (a_bit),
        .b_bit    (b_bit),
        .sa_reset (sa_reset),
        .bit_idx  (bit_idx),
        .last_bit (last_bit),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           abort_k;
        int           reset_k;
    } op_t;

    op_t sb[$];
    op_t plan[$];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    bit  rst_seen = 1'b0;
    bit  in_prog = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_sa_reset"}, sa_reset, 1);
        chk({tag, "_done"},     done, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_a_bit"},    a_bit, 0);
        chk({tag, "_b_bit"},    b_bit, 0);
        chk({tag, "_bit_idx"},  bit_idx, 0);
        chk({tag, "_last_bit"}, last_bit, 0);
    endtask

    always @(posedge reset) rst_seen = 1'b1;

    // Monitor: for each accepted op the expected trace is N bit cycles then one done
    // cycle (cut short by abort or reset); the adder is modelled on the observed bits.
    op_t          mcur;
    int           mk;
    logic         carry;
    logic [N-1:0] ssum;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) continue;
            if (reset) begin
                in_prog = 1'b0;
                rst_seen = 1'b0;
                continue;
            end
            if (rst_seen) begin
                in_prog = 1'b0;
                rst_seen = 1'b0;
            end
            if (in_prog && !busy) begin
                chk("op_len", mk, (mcur.abort_k >= 0) ? mcur.abort_k + 1 : N + 1);
                in_prog = 1'b0;
            end
            if (!in_prog && busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_op", 1, 0);
                end else begin
                    mcur = sb.pop_front();
                    in_prog = 1'b1;
                    mk = 0;
                    carry = 1'b0;
                    ssum = '0;
                end
            end
            if (in_prog) begin
                chk("in_ready_busy", in_ready, 0);
                chk("sa_reset_busy", sa_reset, 0);
                if (mk < N) begin
                    chk("a_bit", a_bit, mcur.a[mk]);
                    chk("b_bit", b_bit, mcur.b[mk]);
                    chk("bit_idx", bit_idx, mk);
                    chk("last_bit", last_bit, (mk == N - 1) ? 1 : 0);
                    chk("done_early", done, 0);
                    ssum[mk] = a_bit ^ b_bit ^ carry;
                    carry = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
                end else if (mk == N) begin
                    chk("done", done, 1);
                    chk("a_bit_done", a_bit, 0);
                    chk("b_bit_done", b_bit, 0);
                    chk("last_bit_done", last_bit, 0);
                    chk("adder_sum", {carry, ssum}, {1'b0, mcur.a} + {1'b0, mcur.b});
                end else begin
                    chk("op_overrun", mk, N);
                    in_prog = 1'b0;
                end
                mk++;
            end else begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_sa_reset", sa_reset, 1);
                chk("idle_a_bit", a_bit, 0);
                chk("idle_b_bit", b_bit, 0);
                chk("idle_done", done, 0);
                chk("idle_last_bit", last_bit, 0);
            end
        end
    end

    // Stimulus: loads the next planned op whenever the DUT is idle, scrambles the
    // operand inputs while busy, and applies planned aborts and mid-cycle resets.
    op_t cur;
    int  c;
    int  pi;
    int  cycles;
    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        abort = 1'b0;
        op_a = '0;
        op_b = '0;

        plan.push_back('{a: 4'b1111, b: 4'b1010, abort_k: -1, reset_k: -1});
        plan.push_back('{a: 4'b1000, b: 4'b0011, abort_k: -1, reset_k: -1});
        plan.push_back('{a: 4'b0110, b: 4'b1011, abort_k: 2,  reset_k: -1});
        plan.push_back('{a: 4'b0101, b: 4'b0101, abort_k: -1, reset_k: -1});
        plan.push_back('{a: 4'b1101, b: 4'b0111, abort_k: -1, reset_k: 1});
        plan.push_back('{a: 4'b1001, b: 4'b1110, abort_k: -1, reset_k: -1});
        for (int i = 0; i < 40; i++) begin
            op_t r;
            r.a = N'($urandom);
            r.b = N'($urandom);
            r.abort_k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            r.reset_k = (r.abort_k < 0 && $urandom_range(0, 11) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            plan.push_back(r);
        end

        #3 reset = 1'b1;
        #1 chk_reset_values("por");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        c = -1;
        pi = 0;
        cycles = 0;
        while (!(pi == plan.size() && c < 0) && cycles < 5000) begin
            if (cycles > 0) @(negedge clk);
            cycles++;
            abort = 1'b0;
            if (c >= 0) begin
                if (c == cur.reset_k) begin
                    in_valid = 1'b0;
                    #2 reset = 1'b1;
                    #1 chk_reset_values("mid_reset");
                    @(negedge clk);
                    reset = 1'b0;
                    c = -1;
                end else begin
                    if (c == cur.abort_k) abort = 1'b1;
                    in_valid = 1'($urandom);
                    op_a = N'($urandom);
                    op_b = N'($urandom);
                    if (c == cur.abort_k || c == N) c = -1;
                    else c++;
                end
            end
            if (c < 0 && in_ready && !reset) begin
                if (pi < plan.size() && (pi < 6 || $urandom_range(0, 3) != 0)) begin
                    cur = plan[pi];
                    pi++;
                    in_valid = 1'b1;
                    op_a = cur.a;
                    op_b = cur.b;
                    sb.push_back(cur);
                    c = 0;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("stim_timeout", (cycles < 5000) ? 1 : 0, 1);

        in_valid = 1'b0;
        for (int i = 0; i < 20 && (sb.size() != 0 || in_prog); i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        chk("drain_idle", in_prog, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
